// File: rtl/mdu_arbiter.sv
// Two-port round-robin arbiter in front of a shared mult/div unit.
// Carries one transaction at a time: IDLE -> ISSUE -> (WAIT) -> RESP.
module mdu_arbiter #(
    parameter int unsigned WDOG = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_0,
    input  logic        req_valid_1,
    input  logic [3:0]  req_op_0,
    input  logic [3:0]  req_op_1,
    input  logic [31:0] req_a_0,
    input  logic [31:0] req_a_1,
    input  logic [31:0] req_b_0,
    input  logic [31:0] req_b_1,
    output logic        req_ready_0,
    output logic        req_ready_1,
    output logic        resp_valid_0,
    output logic        resp_valid_1,
    input  logic        resp_ready_0,
    input  logic        resp_ready_1,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        x_start,
    output logic [3:0]  x_op,
    output logic [31:0] x_d1,
    output logic [31:0] x_d2,
    input  logic [31:0] x_out,
    input  logic        x_busy
);

    localparam int unsigned CntW = (WDOG < 2) ? 1 : $clog2(WDOG + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic            rr_q, rr_d;
    logic            owner_q, owner_d;
    logic [3:0]      op_q, op_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     resp_data_q, resp_data_d;
    logic            resp_err_q, resp_err_d;

    logic grant_0, grant_1;
    logic op_legal, op_long, op_read;
    logic owner_ready;

    // A lone valid requester wins regardless of the round-robin pointer.
    assign grant_0 = req_valid_0 && (!req_valid_1 || !rr_q);
    assign grant_1 = req_valid_1 && (!req_valid_0 || rr_q);

    assign op_legal = (op_q >= 4'd1) && (op_q <= 4'd8);
    assign op_long  = (op_q == 4'd1) || (op_q == 4'd2) || (op_q == 4'd7) || (op_q == 4'd8);
    assign op_read  = (op_q == 4'd5) || (op_q == 4'd6);

    assign owner_ready = owner_q ? resp_ready_1 : resp_ready_0;

    assign resp_data = resp_data_q;
    assign resp_err  = resp_err_q;

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        owner_d      = owner_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        cnt_d        = cnt_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        req_ready_0  = 1'b0;
        req_ready_1  = 1'b0;
        resp_valid_0 = 1'b0;
        resp_valid_1 = 1'b0;
        x_start      = 1'b0;
        x_op         = 4'd0;
        x_d1         = 32'd0;
        x_d2         = 32'd0;

        case (state_q)
            StIdle: begin
                // Ready is suppressed while reset is held so no transfer can be claimed.
                if (reset && !x_busy) begin
                    req_ready_0 = grant_0;
                    req_ready_1 = grant_1;
                    if (grant_0 || grant_1) begin
                        owner_d = grant_1;
                        rr_d    = grant_0;
                        op_d    = grant_1 ? req_op_1 : req_op_0;
                        a_d     = grant_1 ? req_a_1  : req_a_0;
                        b_d     = grant_1 ? req_b_1  : req_b_0;
                        state_d = StIssue;
                    end
                end
            end

            StIssue: begin
                resp_data_d = 32'd0;
                resp_err_d  = 1'b0;
                if (op_legal) begin
                    x_start = 1'b1;
                    x_op    = op_q;
                    x_d1    = a_q;
                    x_d2    = b_q;
                end
                if (op_long) begin
                    cnt_d   = '0;
                    state_d = StWait;
                end else begin
                    if (op_read) begin
                        resp_data_d = x_out;
                    end
                    resp_err_d = !op_legal;
                    state_d    = StResp;
                end
            end

            StWait: begin
                if (!x_busy) begin
                    resp_err_d = 1'b0;
                    state_d    = StResp;
                end else if (cnt_q == CntW'(WDOG)) begin
                    resp_err_d = 1'b1;
                    state_d    = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StResp: begin
                resp_valid_0 = !owner_q;
                resp_valid_1 = owner_q;
                if (owner_ready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            rr_q        <= 1'b0;
            owner_q     <= 1'b0;
            op_q        <= 4'd0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            cnt_q       <= '0;
            resp_data_q <= 32'd0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            owner_q     <= owner_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

endmodule
